// File: rtl/sda_kernel_regs_pkg.sv
// Shared definitions for the kernel control-space interrupt registers:
// local word indices, event bit positions and the access FSM encoding.
package sda_kernel_regs_pkg;

    localparam int IDX_GIE        = 0;
    localparam int IDX_IER        = 1;
    localparam int IDX_ISR        = 2;
    localparam int IDX_DONE_COUNT = 3;

    localparam int EVT_DONE  = 0;
    localparam int EVT_READY = 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACK       = 2'd1,
        ST_WAIT_DROP = 2'd2
    } acc_state_e;

    // Decoded write strobes, one per writable register
    typedef struct packed {
        logic gie;
        logic ier;
        logic isr;
        logic cnt;
    } reg_wr_t;

endpackage

// File: rtl/sda_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at 1 so that event is not lost.
module sda_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= {{(WIDTH-1){1'b0}}, inc};
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sda_kernel_irq_ctrl.sv
// Kernel interrupt controller: GIE/IER/ISR/DONE_COUNT registers behind the
// reg_req/reg_ack port, driving a registered level ap_interrupt.
module sda_kernel_irq_ctrl
    import sda_kernel_regs_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 3,
    parameter int NUM_EVENTS     = 2,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      reg_req,
    output logic                      reg_ack,
    input  logic                      reg_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]               reg_wdata,
    output logic [31:0]               reg_rdata,
    input  logic [NUM_EVENTS-1:0]     event_pulse,
    output logic                      ap_interrupt
);

    acc_state_e             state_q, state_d;
    logic                   sample;
    reg_wr_t                wr;
    logic                   gie_q;
    logic [NUM_EVENTS-1:0]  ier_q, isr_q, tow;
    logic [COUNT_WIDTH-1:0] done_count;
    logic [31:0]            rdata_mux;

    // The access takes effect only on the IDLE edge, so a slow requester
    // holding reg_req cannot trigger a second write or read.
    assign sample = (state_q == ST_IDLE) && reg_req;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (reg_req) state_d = ST_ACK;
            ST_ACK:       state_d = ST_WAIT_DROP;
            ST_WAIT_DROP: if (!reg_req) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_ack = (state_q == ST_ACK);
    end

    always_comb begin
        wr = '0;
        if (sample && reg_write_en) begin
            wr.gie = (reg_addr == REG_ADDR_WIDTH'(IDX_GIE));
            wr.ier = (reg_addr == REG_ADDR_WIDTH'(IDX_IER));
            wr.isr = (reg_addr == REG_ADDR_WIDTH'(IDX_ISR));
            wr.cnt = (reg_addr == REG_ADDR_WIDTH'(IDX_DONE_COUNT));
        end
    end

    assign tow = wr.isr ? reg_wdata[NUM_EVENTS-1:0] : '0;

    always_comb begin
        rdata_mux = '0;
        case (reg_addr)
            REG_ADDR_WIDTH'(IDX_GIE):        rdata_mux = {31'b0, gie_q};
            REG_ADDR_WIDTH'(IDX_IER):        rdata_mux = 32'(ier_q);
            REG_ADDR_WIDTH'(IDX_ISR):        rdata_mux = 32'(isr_q);
            REG_ADDR_WIDTH'(IDX_DONE_COUNT): rdata_mux = 32'(done_count);
            default:                         rdata_mux = '0;
        endcase
    end

    // Events are ORed in after the toggle so a same-cycle set always wins.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gie_q        <= 1'b0;
            ier_q        <= '0;
            isr_q        <= '0;
            reg_rdata    <= '0;
            ap_interrupt <= 1'b0;
        end else begin
            if (wr.gie) gie_q <= reg_wdata[0];
            if (wr.ier) ier_q <= reg_wdata[NUM_EVENTS-1:0];
            isr_q        <= (isr_q ^ tow) | event_pulse;
            if (sample && !reg_write_en) reg_rdata <= rdata_mux;
            ap_interrupt <= gie_q & (|(isr_q & ier_q));
        end
    end

    sda_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_done_count (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (wr.cnt),
        .inc      (event_pulse[EVT_DONE]),
        .count    (done_count)
    );

endmodule
